// File: rtl/req_onehot_arbiter_pkg.sv
// Shared defaults and helpers for the one-hot request arbiter.
// Imported by the debounce line and the arbiter top.
package req_onehot_arbiter_pkg;

    localparam int unsigned DEF_N               = 8;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

    // Width of a counter that must hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Width of an index into n lines, never zero.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/req_onehot_arbiter_line_debounce.sv
// One request line: synchroniser chain, persistence counter and a
// registered pulse marking each debounced 0->1 transition.
module line_debounce
    import req_onehot_arbiter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic deb_o,
    output logic rise_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   deb_q, deb_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d;

    assign s      = sync_q[SYNC_STAGES-1];
    assign deb_o  = deb_q;
    assign rise_o = rise_q;

    // Shift the raw line through the synchroniser flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Count consecutive disagreement; any agreement restarts the count.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        if (s != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d  = s;
                rise_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, counter and rising-edge pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
        end
    end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Debounced request lines latched as pending events and issued one at a
// time, round-robin, as a one-hot word on a valid/ready handshake.
module req_onehot_arbiter
    import req_onehot_arbiter_pkg::*;
#(
    parameter int unsigned N               = DEF_N,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] onehot_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overrun
);

    localparam int unsigned IW = idx_width(N);
    localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

    logic [N-1:0]   deb;
    logic [N-1:0]   rise;

    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   oh_q, oh_d;
    logic           vld_q, vld_d;
    logic [IW-1:0]  last_q, last_d;
    logic           ovr_q, ovr_d;

    logic           load;
    logic [N-1:0]   clr;
    logic [IW:0]    sh;
    logic [2*N-1:0] rot_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;
    logic [2*N-1:0] back_dbl;
    logic [N-1:0]   grant;
    logic [IW-1:0]  grant_idx;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_line
            line_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_line (
                .clk   (clk),
                .rst   (rst),
                .raw_i (req_in[g]),
                .deb_o (deb[g]),
                .rise_o(rise[g])
            );
        end
    endgenerate

    assign onehot_out = oh_q;
    assign out_valid  = vld_q;
    assign pending    = pend_q;
    assign overrun    = ovr_q;

    // Round-robin pick: rotate so last_idx+1 sits at bit 0, take the
    // lowest set bit, rotate back into place.
    always_comb begin
        sh        = {1'b0, last_q} + 1'b1;
        rot_dbl   = {pend_q, pend_q} >> sh;
        rot       = rot_dbl[N-1:0];
        pick      = rot & (~rot + 1'b1);
        back_dbl  = {pick, pick} << sh;
        grant     = back_dbl[2*N-1:N];
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    // Handshake, pending set/clear (set wins) and overrun detection.
    always_comb begin
        load   = (|pend_q) && (!vld_q || out_ready);
        clr    = load ? grant : '0;
        pend_d = (pend_q & ~clr) | rise;
        ovr_d  = |(rise & pend_q & ~clr);
        oh_d   = oh_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (load) begin
            oh_d   = grant;
            vld_d  = 1'b1;
            last_d = grant_idx;
        end else if (vld_q && out_ready) begin
            oh_d  = '0;
            vld_d = 1'b0;
        end
    end

    // Pending set, output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            oh_q   <= '0;
            vld_q  <= 1'b0;
            last_q <= LAST_INIT;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            oh_q   <= oh_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            ovr_q  <= ovr_d;
        end
    end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Scoreboard bench for req_onehot_arbiter: directed stimulus pushes
// expected grants, a negedge monitor pops them on each handshake.
module tb_req_onehot_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_in;
    logic [N-1:0] onehot_out;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         overrun;

    int tests;
    int fails;
    int ov_cnt;
    int ov_base;
    logic [N-1:0] sb[$];

    req_onehot_arbiter #(
        .N(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .onehot_out(onehot_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!out_valid && i < 40) begin
            step(1);
            i++;
        end
        chk({name, "_timeout"}, {31'd0, out_valid}, 32'd1);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (overrun) ov_cnt++;
        if (out_valid) begin
            chk("onehot_inv", {31'd0, $onehot(onehot_out)}, 32'd1);
        end else begin
            chk("zero_inv", {24'd0, onehot_out}, 32'd0);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", {24'd0, onehot_out}, 32'd0);
            end else begin
                chk("sb_grant", {24'd0, onehot_out}, {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        tests = 0; fails = 0; ov_cnt = 0; ov_base = 0;
        rst = 1'b1; req_in = 8'hFF; out_ready = 1'b0;

        // 1 reset
        step(4);
        chk("rst_onehot",  {24'd0, onehot_out}, 32'd0);
        chk("rst_valid",   {31'd0, out_valid},  32'd0);
        chk("rst_pending", {24'd0, pending},    32'd0);
        chk("rst_overrun", {31'd0, overrun},    32'd0);
        rst = 1'b0; req_in = 8'h00;
        step(12);
        chk("idle_valid",   {31'd0, out_valid}, 32'd0);
        chk("idle_pending", {24'd0, pending},   32'd0);

        // 2 latency
        out_ready = 1'b1;
        sb.push_back(8'h04);
        req_in = 8'h04;
        step(7);
        chk("lat_valid_e6",   {31'd0, out_valid}, 32'd0);
        chk("lat_pending_e6", {24'd0, pending},   32'h04);
        step(1);
        chk("lat_valid_e7",   {31'd0, out_valid},  32'd1);
        chk("lat_onehot_e7",  {24'd0, onehot_out}, 32'h04);
        chk("lat_pending_e7", {24'd0, pending},    32'd0);
        step(1);
        chk("lat_valid_e8", {31'd0, out_valid}, 32'd0);
        req_in = 8'h00;
        step(12);

        // 3 glitch then accepted pulse
        req_in = 8'h02;
        step(3);
        req_in = 8'h00;
        step(15);
        chk("glitch_pending", {24'd0, pending}, 32'd0);
        chk("glitch_queue", sb.size(), 32'd0);
        sb.push_back(8'h02);
        req_in = 8'h02;
        step(4);
        req_in = 8'h00;
        step(15);
        chk("pulse4_queue", sb.size(), 32'd0);

        // 4 round-robin from a fresh pointer
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(8'h01);
            sb.push_back(8'h80);
            req_in = 8'h81;
            wait_valid("rr_wait");
            chk("rr_first",  {24'd0, onehot_out}, 32'h01);
            step(1);
            chk("rr_b2b_vld", {31'd0, out_valid},  32'd1);
            chk("rr_second",  {24'd0, onehot_out}, 32'h80);
            step(1);
            chk("rr_done", {31'd0, out_valid}, 32'd0);
            req_in = 8'h00;
            step(12);
        end

        // 5 backpressure and overrun
        out_ready = 1'b0;
        req_in = 8'h02;
        wait_valid("bp_wait");
        chk("bp_shown", {24'd0, onehot_out}, 32'h02);
        ov_base = ov_cnt;
        req_in = 8'h0A;
        step(12);
        chk("bp_pend1", {24'd0, pending}, 32'h08);
        chk("bp_no_ovr", ov_cnt - ov_base, 32'd0);
        req_in = 8'h02;
        step(12);
        req_in = 8'h0A;
        step(12);
        chk("bp_stable_oh", {24'd0, onehot_out}, 32'h02);
        chk("bp_stable_v",  {31'd0, out_valid},  32'd1);
        chk("bp_pend2",     {24'd0, pending},    32'h08);
        chk("bp_overrun",   ov_cnt - ov_base,    32'd1);
        sb.push_back(8'h02);
        sb.push_back(8'h08);
        out_ready = 1'b1;
        step(3);
        chk("bp_drain", {31'd0, out_valid}, 32'd0);
        chk("bp_queue", sb.size(), 32'd0);
        req_in = 8'h00;
        step(12);

        // 6 async reset mid-handshake
        out_ready = 1'b0;
        req_in = 8'h30;
        wait_valid("ar_wait");
        chk("ar_shown",   {24'd0, onehot_out}, 32'h10);
        chk("ar_pending", {24'd0, pending},    32'h20);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid",   {31'd0, out_valid},  32'd0);
        chk("ar_pend0",   {24'd0, pending},    32'd0);
        chk("ar_onehot",  {24'd0, onehot_out}, 32'd0);
        req_in = 8'h00;
        step(2);
        rst = 1'b0;
        step(5);
        chk("final_queue", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
